// File: rtl/irq_ctrl_if.sv
// Bus port bundle for irq_ctrl: read/write strobes, byte address, write data
// and the combinational read-data return.
interface irq_ctrl_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Three-source prioritised interrupt controller with EN/PEND/ID/EOI registers.
// Define IRQ_CTRL_EDGE_EN for edge-triggered pending capture (default: level).
module irq_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   src_irq,
  irq_ctrl_if.slave    bus,
  output logic         irq_out
);

  localparam logic [31:0] EN_ADDR   = 32'h4000_0030;
  localparam logic [31:0] PEND_ADDR = 32'h4000_0034;
  localparam logic [31:0] ID_ADDR   = 32'h4000_0038;
  localparam logic [31:0] EOI_ADDR  = 32'h4000_003C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SERVICE
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] en_q, en_d;
  logic [2:0] pend_q, pend_d;
  logic [1:0] isr_q, isr_d;
  logic       irq_out_q, irq_out_d;

  logic [2:0] active;
  logic [1:0] winner;
  logic [2:0] pend_set;
  logic [2:0] pend_clr;
  logic       id_rd;
  logic       eoi_wr;
  logic       id_valid;

`ifdef IRQ_CTRL_EDGE_EN
  logic [2:0] src_hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) src_hist_q <= '0;
    else       src_hist_q <= src_irq;
  end

  assign pend_set = src_irq & ~src_hist_q;
`else
  assign pend_set = src_irq;
`endif

  always_comb begin
    active = pend_q & en_q;
    winner = 2'd0;
    if (active[0])      winner = 2'd0;
    else if (active[1]) winner = 2'd1;
    else if (active[2]) winner = 2'd2;
  end

  // ID is only meaningful while asserting with a live winner; otherwise it reads 0.
  assign id_valid = (state_q == ST_ASSERT) && (active != 3'b000);
  assign id_rd    = bus.rd && (bus.addr == ID_ADDR);
  assign eoi_wr   = bus.wr && (bus.addr == EOI_ADDR);

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      case (bus.addr)
        EN_ADDR:   bus.rdata = {29'b0, en_q};
        PEND_ADDR: bus.rdata = {29'b0, pend_q};
        ID_ADDR:   bus.rdata = id_valid ? {1'b1, 29'b0, winner} : '0;
        default:   bus.rdata = '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    isr_d    = isr_q;
    pend_clr = '0;

    if (bus.wr && (bus.addr == EN_ADDR))   en_d = bus.wdata[2:0];
    if (bus.wr && (bus.addr == PEND_ADDR)) pend_clr = bus.wdata[2:0];

    case (state_q)
      ST_IDLE: begin
        if (active != 3'b000) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (active == 3'b000) begin
          state_d = ST_IDLE;
        end else if (id_rd) begin
          state_d = ST_SERVICE;
          isr_d   = winner;
        end
      end
      ST_SERVICE: begin
        if (eoi_wr) begin
          state_d  = ST_IDLE;
          pend_clr = pend_clr | (3'b001 << isr_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new set in the same cycle as a clear wins.
    pend_d    = (pend_q & ~pend_clr) | pend_set;
    irq_out_d = (state_d == ST_ASSERT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= '0;
      pend_q    <= '0;
      isr_q     <= '0;
      irq_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      isr_q     <= isr_d;
      irq_out_q <= irq_out_d;
    end
  end

  assign irq_out = irq_out_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scoreboard bench for irq_ctrl; expectations adapt to IRQ_CTRL_EDGE_EN.
module tb_irq_ctrl;

  localparam logic [31:0] EN_A   = 32'h4000_0030;
  localparam logic [31:0] PEND_A = 32'h4000_0034;
  localparam logic [31:0] ID_A   = 32'h4000_0038;
  localparam logic [31:0] EOI_A  = 32'h4000_003C;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] src_irq;
  logic       irq_out;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  irq_ctrl_if bus ();

  irq_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .src_irq (src_irq),
    .bus     (bus),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t x;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %h, expected queued entry", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_fail++;
        $error("FAIL %s: got %h, expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic rd_chk(input logic [31:0] a, input string tag, input logic [31:0] e);
    push_exp(tag, e);
    bus.rd   = 1'b1;
    bus.addr = a;
    #1;
    pop_cmp(bus.rdata);
    tick();
    bus.rd   = 1'b0;
    bus.addr = '0;
  endtask

  task automatic wr_bus(input logic [31:0] a, input logic [31:0] d);
    bus.wr    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic irq_chk(input string tag, input logic e);
    push_exp(tag, {31'b0, e});
    pop_cmp({31'b0, irq_out});
  endtask

  initial begin
    reset     = 1'b1;
    src_irq   = '0;
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    tick();
    tick();
    irq_chk("reset_irq", 1'b0);
    reset = 1'b0;
    rd_chk(EN_A,   "reset_en",   32'h0);
    rd_chk(PEND_A, "reset_pend", 32'h0);
    rd_chk(ID_A,   "reset_id",   32'h0);
    irq_chk("idle_irq", 1'b0);

    // Single source 1 pulse
    wr_bus(EN_A, 32'h7);
    rd_chk(EN_A, "en_readback", 32'h7);
    src_irq = 3'b010;
    tick();
    src_irq = 3'b000;
    irq_chk("pulse_irq_one_edge", 1'b0);
    rd_chk(PEND_A, "pulse_pend", 32'h2);
    irq_chk("pulse_irq_two_edges", 1'b1);
    rd_chk(ID_A, "pulse_id", 32'h8000_0001);
    irq_chk("service_irq_low", 1'b0);
    rd_chk(PEND_A, "service_pend_held", 32'h2);
    wr_bus(EOI_A, 32'h0);
    irq_chk("eoi_irq", 1'b0);
    rd_chk(PEND_A, "eoi_pend_clear", 32'h0);

    // Sources 2 and 0 together: priority and EOI re-assert
    src_irq = 3'b101;
    tick();
    src_irq = 3'b000;
    rd_chk(ID_A, "idle_id_zero", 32'h0);
    irq_chk("multi_irq", 1'b1);
    rd_chk(ID_A, "multi_id0", 32'h8000_0000);
    rd_chk(ID_A, "service_id_zero", 32'h0);
    irq_chk("service_irq_after_id", 1'b0);
    wr_bus(EOI_A, 32'h0);
    irq_chk("eoi_next_irq_low", 1'b0);
    tick();
    irq_chk("eoi_next_irq_high", 1'b1);
    rd_chk(PEND_A, "multi_pend_after_eoi", 32'h4);
    rd_chk(ID_A, "multi_id2", 32'h8000_0002);
    wr_bus(EOI_A, 32'h0);
    rd_chk(PEND_A, "multi_pend_final", 32'h0);

    // Disable while asserting
    src_irq = 3'b010;
    tick();
    src_irq = 3'b000;
    tick();
    irq_chk("dis_irq_before", 1'b1);
    wr_bus(EN_A, 32'h0);
    tick();
    irq_chk("dis_irq_after", 1'b0);
    rd_chk(PEND_A, "dis_pend_kept", 32'h2);
    rd_chk(ID_A, "dis_id_zero", 32'h0);
    wr_bus(PEND_A, 32'h2);
    rd_chk(PEND_A, "w1c_clear", 32'h0);

    // Same-cycle set and W1C, then source held high
    src_irq   = 3'b001;
    bus.wr    = 1'b1;
    bus.addr  = PEND_A;
    bus.wdata = 32'h1;
    tick();
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    rd_chk(PEND_A, "set_beats_clear", 32'h1);
    wr_bus(PEND_A, 32'h1);
`ifdef IRQ_CTRL_EDGE_EN
    rd_chk(PEND_A, "held_src_w1c", 32'h0);
`else
    rd_chk(PEND_A, "held_src_w1c", 32'h1);
`endif
    src_irq = 3'b000;
    wr_bus(PEND_A, 32'h1);
    rd_chk(PEND_A, "released_src_w1c", 32'h0);

    // Reset while in service
    wr_bus(EN_A, 32'h7);
    src_irq = 3'b001;
    tick();
    src_irq = 3'b000;
    tick();
    irq_chk("pre_reset_irq", 1'b1);
    rd_chk(ID_A, "pre_reset_id", 32'h8000_0000);
    reset = 1'b1;
    #2;
    irq_chk("in_reset_irq", 1'b0);
    rd_chk(EN_A, "in_reset_en", 32'h0);
    rd_chk(PEND_A, "in_reset_pend", 32'h0);
    reset = 1'b0;
    rd_chk(ID_A, "post_reset_id", 32'h0);
    src_irq = 3'b100;
    tick();
    src_irq = 3'b000;
    wr_bus(EOI_A, 32'h0);
    rd_chk(PEND_A, "post_reset_eoi_ignored", 32'h4);
    irq_chk("post_reset_irq", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have the ports below, clock and reset first; reset SHALL be asynchronous and active-high.
- clk  in  1  CPU clock
- reset  in  1  async active-high reset
- src_irq  in  3  interrupt sources: [0] peripheral timer, [1] UART RX, [2] UART TX
- rd  in  1  bus read strobe
- wr  in  1  bus write strobe
- addr  in  32  bus byte address
- wdata  in  32  bus write data
- rdata  out  32  bus read data, zero when not addressed (OR-ed onto shared read bus)
- irq_out  out  1  interrupt request to CPU (CPU gates it with kernel-mode bit)
REQ-002 The block SHALL decode four word registers: EN 0x4000_0030, PEND 0x4000_0034, ID 0x4000_0038, EOI 0x4000_003C.

Function
REQ-003 EN[2:0] SHALL be read/write; bits [31:3] SHALL read 0.
REQ-004 PEND[2:0] SHALL set per source per REQ-015/016 and clear on write with wdata bit = 1 (write-1-clear); a set and a clear of the same bit in one cycle SHALL leave the bit set.
REQ-005 rdata SHALL be combinational: the addressed register when rd=1 and addr matches, else 32'h0.
REQ-006 Active set SHALL be PEND & EN; the winner SHALL be the lowest-numbered active bit (bit 0 highest priority).
REQ-007 The controller SHALL be a 3-state FSM: IDLE, ASSERT, SERVICE.
REQ-008 IDLE -> ASSERT on the clock edge where the active set is non-zero.
REQ-009 ASSERT -> IDLE when the active set becomes zero (disable or clear) before acknowledge.
REQ-010 ASSERT -> SERVICE on an ID read; that read SHALL return {1'b1, 29'b0, winner[1:0]} and capture winner into in-service register isr[1:0].
REQ-011 ID read in IDLE or SERVICE SHALL return 32'h0 and change no state.
REQ-012 SERVICE -> IDLE on any write to EOI; the write SHALL also clear PEND[isr]; EOI writes in IDLE/ASSERT SHALL be ignored.
REQ-013 irq_out SHALL be 1 exactly when state = ASSERT (registered, no glitches).
REQ-014 Latency: active set non-zero at edge n -> irq_out=1 after edge n+1; EOI at edge n with another source pending -> irq_out=1 after edge n+2 (via IDLE).

Reset
REQ-017 While reset=1: state=IDLE, EN=0, PEND=0, isr=0, edge-detect history=0, irq_out=0; rdata follows REQ-005 using these values.
REQ-018 Reset asserted mid-ASSERT or mid-SERVICE SHALL abandon the interrupt without requiring EOI.

Configuration
REQ-015 With IRQ_CTRL_EDGE_EN defined, PEND[i] SHALL set on a sampled 0->1 transition of src_irq[i] (one-cycle history register), independent of EN.
REQ-016 Without IRQ_CTRL_EDGE_EN, PEND[i] SHALL set every cycle src_irq[i]=1 (level-sensitive; W1C is effective only once the source deasserts), and no history register SHALL be built.

Verification
REQ-019 Benches SHALL cover, in both macro settings where relevant:
- Reset, no stimulus -> irq_out=0, read EN/PEND/ID = 0x0/0x0/0x0.
- EN=0x7, pulse src_irq[1] one cycle (edge build) -> PEND=0x2, irq_out=1 two edges after pulse, ID read = 0x8000_0001, irq_out=0 next cycle.
- PEND bits 2 and 0 both set, EN=0x7 -> ID read = 0x8000_0000; EOI write -> PEND=0x4, irq_out re-asserts two edges later, ID = 0x8000_0002.
- In ASSERT with winner 1, write EN=0x0 -> state IDLE, irq_out=0, PEND unchanged=0x2, ID read = 0x0.
- Same-cycle src_irq[0] rising edge and W1C PEND=0x1 -> PEND[0] remains 1.
- Reset asserted in SERVICE -> all registers 0, irq_out=0; EOI after reset release has no effect.
